// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO register pair.
// The multiplier holds its latched operands for MUL_STAGES-1 cycles; the divider is restoring, DIV_STEP bits per cycle.
module muldiv_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned DIV_STEP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int unsigned DIV_ITERS = DATA_W / DIV_STEP;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS + MUL_STAGES);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;
  typedef enum logic [2:0] {
    OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
    OP_DIVU = 3'b011, OP_MTHI  = 3'b100, OP_MTLO = 3'b101
  } op_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   ma_q, ma_d, mb_q, mb_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return (~x) + DATA_W'(1);
  endfunction

  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rem,
                                                   input logic [DATA_W-1:0] quo,
                                                   input logic [DATA_W-1:0] dvs);
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] r, q;
    r = rem;
    q = quo;
    for (int unsigned i = 0; i < DIV_STEP; i++) begin
      trial = {r, q[DATA_W-1]};
      if (trial >= {1'b0, dvs}) begin
        trial = trial - {1'b0, dvs};
        q     = {q[DATA_W-2:0], 1'b1};
      end else begin
        q     = {q[DATA_W-2:0], 1'b0};
      end
      r = trial[DATA_W-1:0];
    end
    return {r, q};
  endfunction

  logic                is_signed, n1, n2;
  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W:0]     mul_src_a, mul_src_b;
  logic [2*DATA_W-1:0] mul_a, mul_b, prod;
  logic [DATA_W-1:0]   step_rem_in, step_quo_in, step_dvs_in, step_rem, step_quo;
  logic                accept;

  assign is_signed = ~req_op[0];
  assign n1        = is_signed & src1[DATA_W-1];
  assign n2        = is_signed & src2[DATA_W-1];
  assign mag1      = n1 ? negate(src1) : src1;
  assign mag2      = n2 ? negate(src2) : src2;
  assign mul_src_a = {n1, src1};
  assign mul_src_b = {n2, src2};

  // Low half of a product of sign-extended operands is the two's-complement product.
  assign mul_a = (MUL_STAGES == 1) ? {{(DATA_W-1){mul_src_a[DATA_W]}}, mul_src_a}
                                   : {{(DATA_W-1){ma_q[DATA_W]}}, ma_q};
  assign mul_b = (MUL_STAGES == 1) ? {{(DATA_W-1){mul_src_b[DATA_W]}}, mul_src_b}
                                   : {{(DATA_W-1){mb_q[DATA_W]}}, mb_q};
  assign prod  = mul_a * mul_b;

  // The first iteration runs on the accept edge so that DIV + FIX fit the fixed latency.
  assign step_rem_in = (state_q == S_IDLE) ? '0   : rem_q;
  assign step_quo_in = (state_q == S_IDLE) ? mag1 : quo_q;
  assign step_dvs_in = (state_q == S_IDLE) ? mag2 : dvs_q;
  assign {step_rem, step_quo} = div_step(step_rem_in, step_quo_in, step_dvs_in);

  assign req_ready = (state_q == S_IDLE) && !cancel;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    ma_d    = ma_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MULT, OP_MULTU: begin
              ma_d = mul_src_a;
              mb_d = mul_src_b;
              if (MUL_STAGES == 1) begin
                {hi_d, lo_d} = prod;
                done_d       = 1'b1;
              end else begin
                state_d = S_MUL;
                cnt_d   = CNT_W'(MUL_STAGES - 2);
              end
            end
            OP_DIV, OP_DIVU: begin
              rem_d   = step_rem;
              quo_d   = step_quo;
              dvs_d   = mag2;
              qneg_d  = n1 ^ n2;
              rneg_d  = n1;
              dz_d    = (src2 == '0);
              state_d = S_DIV;
              cnt_d   = CNT_W'(DIV_ITERS - 2);
            end
            OP_MTHI: begin
              hi_d   = src1;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = src1;
              done_d = 1'b1;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          // Divide-by-zero leaves the all-ones quotient unsigned; the remainder fix restores src1.
          lo_d    = (qneg_q && !dz_q) ? negate(quo_q) : quo_q;
          hi_d    = rneg_q ? negate(rem_q) : rem_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

endmodule
